// File: rtl/systolic_pe_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pe_pkg
// Shared constants for the weight-stationary systolic processing element.
//   DEFAULT_DATA_WIDTH : default activation/weight width
//   DEFAULT_ACC_WIDTH  : default partial-sum width
//   MODE_INT8/MODE_INT4: encodings of the quantize_mode input
//   INT4_WIDTH         : operand width used in INT4 mode (low nibble)
// ---------------------------------------------------------------------------
package systolic_pe_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ACC_WIDTH  = 32;

    localparam logic MODE_INT8 = 1'b0;
    localparam logic MODE_INT4 = 1'b1;

    localparam int INT4_WIDTH = 4;

endpackage : systolic_pe_pkg

// File: rtl/systolic_pe_mac_unit.sv
// ---------------------------------------------------------------------------
// pe_mac_unit
// Combinational multiply-accumulate datapath of one systolic PE.
// Selects operands by quantisation mode (full signed word, or sign-extended
// low nibble), multiplies them and adds the incoming partial sum with
// two's-complement wrap.
// Ports:
//   quantize_mode : MODE_INT8 / MODE_INT4
//   act           : raw activation
//   weight        : raw stored weight
//   psum_in       : partial sum from the PE above
//   sum           : psum_in + act*weight, ACC_WIDTH bits, wrapping
// ---------------------------------------------------------------------------
module pe_mac_unit
    import systolic_pe_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH
) (
    input  logic                  quantize_mode,
    input  logic [DATA_WIDTH-1:0] act,
    input  logic [DATA_WIDTH-1:0] weight,
    input  logic [ACC_WIDTH-1:0]  psum_in,
    output logic [ACC_WIDTH-1:0]  sum
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    logic signed [DATA_WIDTH-1:0] a_sel;
    logic signed [DATA_WIDTH-1:0] w_sel;
    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]  prod_ext;

    // In INT4 mode the upper bits of both operands are ignored; the nibble is
    // sign-extended so the multiplier always sees a DATA_WIDTH signed value.
    always_comb begin
        if (quantize_mode == MODE_INT4) begin
            a_sel = DATA_WIDTH'($signed(act[INT4_WIDTH-1:0]));
            w_sel = DATA_WIDTH'($signed(weight[INT4_WIDTH-1:0]));
        end else begin
            a_sel = $signed(act);
            w_sel = $signed(weight);
        end
    end

    // Operands are widened to the full product width first so the multiply is
    // evaluated at PROD_WIDTH bits with correct signed semantics.
    assign prod     = PROD_WIDTH'(a_sel) * PROD_WIDTH'(w_sel);
    assign prod_ext = ACC_WIDTH'(prod);
    assign sum      = psum_in + prod_ext;

endmodule : pe_mac_unit

// File: rtl/systolic_pe.sv
// ---------------------------------------------------------------------------
// systolic_pe
// Weight-stationary processing element of a 2-D systolic MAC array.
// Holds one weight; on each enabled cycle registers psum_in + act_in*weight
// downward and forwards act_in to the right.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   enable         : advances act_out / psum_out
//   load_weight    : captures weight_load_in (independent of enable)
//   quantize_mode  : 0 = INT8, 1 = INT4 (low nibbles)
//   act_in         : activation from the left neighbour
//   psum_in        : partial sum from the upper neighbour
//   weight_load_in : weight value to store
//   act_out        : registered act_in (raw) to the right neighbour
//   psum_out       : registered MAC result to the lower neighbour
// ---------------------------------------------------------------------------
module systolic_pe
    import systolic_pe_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load_weight,
    input  logic                  quantize_mode,
    input  logic [DATA_WIDTH-1:0] act_in,
    input  logic [ACC_WIDTH-1:0]  psum_in,
    input  logic [DATA_WIDTH-1:0] weight_load_in,
    output logic [DATA_WIDTH-1:0] act_out,
    output logic [ACC_WIDTH-1:0]  psum_out
);

    logic [DATA_WIDTH-1:0] weight_reg;
    logic [DATA_WIDTH-1:0] act_reg;
    logic [ACC_WIDTH-1:0]  psum_reg;
    logic [ACC_WIDTH-1:0]  sum_next;

    // The MAC always reads the currently stored weight, so a load coinciding
    // with an enabled cycle only affects the following cycle's result.
    pe_mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .quantize_mode (quantize_mode),
        .act           (act_in),
        .weight        (weight_reg),
        .psum_in       (psum_in),
        .sum           (sum_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_reg <= '0;
        end else if (load_weight) begin
            weight_reg <= weight_load_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_reg  <= '0;
            psum_reg <= '0;
        end else if (enable) begin
            act_reg  <= act_in;
            psum_reg <= sum_next;
        end
    end

    assign act_out  = act_reg;
    assign psum_out = psum_reg;

endmodule : systolic_pe

// File: tb/tb_systolic_pe.sv
// ---------------------------------------------------------------------------
// tb_systolic_pe
// Directed-vector bench for systolic_pe with a behavioural reference model
// and per-cycle comparison, plus literal expectations at key points.
// ---------------------------------------------------------------------------
module tb_systolic_pe;

    localparam int DW = 8;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          enable = 1'b0;
    logic          load_weight = 1'b0;
    logic          quantize_mode = 1'b0;
    logic [DW-1:0] act_in = '0;
    logic [AW-1:0] psum_in = '0;
    logic [DW-1:0] weight_load_in = '0;
    logic [DW-1:0] act_out;
    logic [AW-1:0] psum_out;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_on = 1'b0;

    systolic_pe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .load_weight    (load_weight),
        .quantize_mode  (quantize_mode),
        .act_in         (act_in),
        .psum_in        (psum_in),
        .weight_load_in (weight_load_in),
        .act_out        (act_out),
        .psum_out       (psum_out)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Operand value as a plain integer: full signed byte, or signed nibble.
    function automatic int operand_value(input bit mode, input logic [DW-1:0] raw);
        int v;
        if (mode) begin
            v = int'(raw & 8'h0F);
            if (v >= 8) v = v - 16;
        end else begin
            v = int'(raw);
            if (v >= 128) v = v - 256;
        end
        return v;
    endfunction

    function automatic logic [AW-1:0] model_mac(input bit mode, input logic [DW-1:0] a,
                                                input logic [DW-1:0] w, input logic [AW-1:0] p);
        longint total;
        total = longint'($signed(p)) + longint'(operand_value(mode, a) * operand_value(mode, w));
        return total[AW-1:0];
    endfunction

    logic [DW-1:0] m_weight = '0;
    logic [DW-1:0] m_act    = '0;
    logic [AW-1:0] m_psum   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_weight <= '0;
            m_act    <= '0;
            m_psum   <= '0;
        end else begin
            if (enable) begin
                m_psum <= model_mac(quantize_mode, act_in, m_weight, psum_in);
                m_act  <= act_in;
            end
            if (load_weight) m_weight <= weight_load_in;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            vectors++;
            if (psum_out !== m_psum || act_out !== m_act) begin
                miscompares++;
                $display("FAIL model_cmp t=%0t: psum_out=%h act_out=%h, model psum=%h act=%h",
                         $time, psum_out, act_out, m_psum, m_act);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_lit(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    // Apply one vector on the falling edge, let one rising edge pass, settle.
    task automatic cycle(input bit en, input bit ld, input bit mode, input logic [DW-1:0] wt,
                         input logic [DW-1:0] a, input logic [AW-1:0] p);
        @(negedge clk);
        enable         = en;
        load_weight    = ld;
        quantize_mode  = mode;
        weight_load_in = wt;
        act_in         = a;
        psum_in        = p;
        @(posedge clk);
        #2;
    endtask

    typedef struct {
        bit            mode;
        logic [DW-1:0] wt;
        logic [DW-1:0] a;
        logic [AW-1:0] p;
    } vec_t;

    vec_t table_v[6] = '{
        '{1'b0, 8'h7F, 8'h7F, 32'h0000_0000},
        '{1'b0, 8'h7F, 8'h81, 32'hFFFF_FFFF},
        '{1'b1, 8'hF7, 8'hA9, 32'h0000_0010},
        '{1'b0, 8'hFF, 8'hFF, 32'h8000_0000},
        '{1'b1, 8'h07, 8'h17, 32'h7FFF_FFF0},
        '{1'b0, 8'h01, 8'h80, 32'h0000_0000}
    };

    // ---------------- stimulus ----------------
    initial begin
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check_lit("reset_psum", psum_out, 32'h0);
        check_lit("reset_act", AW'(act_out), 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_on = 1'b1;

        // 1: load weight 2, then 10*2
        cycle(1, 1, 0, 8'h02, 8'h00, 32'h0);
        cycle(1, 0, 0, 8'h00, 8'd10, 32'h0);
        check_lit("t1_psum", psum_out, 32'd20);
        // 2: 5*2 + 100
        cycle(1, 0, 0, 8'h00, 8'd5, 32'd100);
        check_lit("t2_psum", psum_out, 32'd110);
        // 3: weight -3, 4*-3
        cycle(1, 1, 0, 8'hFD, 8'h00, 32'h0);
        cycle(1, 0, 0, 8'h00, 8'h04, 32'h0);
        check_lit("t3_psum", psum_out, 32'hFFFF_FFF4);
        // 4: INT4, weight nibble 2, act nibble -3
        cycle(1, 1, 1, 8'h22, 8'h00, 32'h0);
        cycle(1, 0, 1, 8'h00, 8'h3D, 32'h0);
        check_lit("t4_psum", psum_out, 32'hFFFF_FFFA);
        check_lit("t4_act", AW'(act_out), 32'h0000_003D);
        // 5a: hold with enable low
        cycle(0, 0, 0, 8'h00, 8'h55, 32'd12345);
        cycle(0, 0, 1, 8'h00, 8'hAA, 32'd999);
        check_lit("t5_hold_psum", psum_out, 32'hFFFF_FFFA);
        check_lit("t5_hold_act", AW'(act_out), 32'h0000_003D);
        // 5b: load + enable together: old weight 0x22 (34) in INT8, then new 3
        cycle(1, 1, 0, 8'h03, 8'h02, 32'h0);
        check_lit("t5_overlap_old", psum_out, 32'd68);
        cycle(1, 0, 0, 8'h00, 8'h02, 32'h0);
        check_lit("t5_overlap_new", psum_out, 32'd6);
        // 6: INT8 extreme with wrap
        cycle(1, 1, 0, 8'h80, 8'h00, 32'h0);
        cycle(1, 0, 0, 8'h00, 8'h80, 32'h7FFF_FFFF);
        check_lit("t6_int8_wrap", psum_out, 32'h8000_3FFF);
        // 6: INT4 extreme
        cycle(1, 1, 1, 8'h08, 8'h00, 32'h0);
        cycle(1, 0, 1, 8'h00, 8'h08, 32'h0);
        check_lit("t6_int4_min", psum_out, 32'd64);

        // extra directed table, checked by the model
        for (int i = 0; i < 6; i++) begin
            cycle(1, 1, table_v[i].mode, table_v[i].wt, 8'h00, 32'h0);
            cycle(1, 0, table_v[i].mode, 8'h00, table_v[i].a, table_v[i].p);
        end
        check_lit("tbl_last", psum_out, 32'hFFFF_FF80);

        // 6: reset mid-cycle clears everything immediately
        cycle(1, 0, 0, 8'h00, 8'h33, 32'h1234);
        #1 rst_n = 1'b0;
        #1;
        check_lit("t6_rst_psum", psum_out, 32'h0);
        check_lit("t6_rst_act", AW'(act_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        // weight was cleared too: 7*0
        cycle(1, 0, 0, 8'h00, 8'h07, 32'h0);
        check_lit("t6_weight_cleared", psum_out, 32'h0);
        cycle(1, 1, 0, 8'h01, 8'h00, 32'h0);
        cycle(1, 0, 0, 8'h00, 8'h07, 32'h0);
        check_lit("t6_reload", psum_out, 32'd7);

        @(negedge clk);
        #1;
        cmp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_systolic_pe

// File: doc/systolic_pe.md
Name: systolic_pe

Overview:
Weight-stationary processing element for a 2-D systolic MAC array.
- Holds one signed weight, loaded on demand.
- Each enabled cycle it multiplies the incoming activation by the stored weight and adds the partial sum from the PE above. It registers the result downward and forwards the activation to the PE on the right.
- Supports signed INT8 operation, and INT4 operation using the low nibbles of the operands.

Parameters:
- DATA_WIDTH, 8, activation/weight width in bits (INT4 mode uses bits [3:0]).
- ACC_WIDTH, 32, partial-sum width in bits; must be ≥ 2*DATA_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  advances the activation and partial-sum pipeline registers.
- load_weight  input  1  captures weight_load_in into the weight register.
- quantize_mode  input  1  0 = INT8, 1 = INT4.
- act_in  input  DATA_WIDTH  signed activation from the left neighbour.
- psum_in  input  ACC_WIDTH  signed partial sum from the upper neighbour.
- weight_load_in  input  DATA_WIDTH  signed weight value to store.
- act_out  output  DATA_WIDTH  registered copy of act_in, to the right neighbour.
- psum_out  output  ACC_WIDTH  registered MAC result, to the lower neighbour.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. While rst_n=0: weight_reg=0, act_out=0, psum_out=0.
- Weight register:
  - On a posedge with load_weight=1: weight_reg <= weight_load_in (all DATA_WIDTH bits stored).
  - The load is independent of enable.
  - Otherwise weight_reg holds.
- Operand select (combinational, from the current quantize_mode):
  - INT8: a = signed act_in, w = signed weight_reg.
  - INT4: a = sign-extend(act_in[3:0]), w = sign-extend(weight_reg[3:0]). Bits above [3] are ignored.
- Product and sum:
  - prod = a*w, signed, 2*DATA_WIDTH bits.
  - sum = psum_in + sign-extend(prod) to ACC_WIDTH.
  - Two's-complement wrap modulo 2^ACC_WIDTH; no saturation.
- Pipeline update on a posedge with enable=1:
  - psum_out <= sum.
  - act_out <= act_in (raw, unmasked, in both modes).
- Latency: 1 cycle from act_in/psum_in to psum_out/act_out.
- enable=0: act_out and psum_out hold.
- Simultaneous load_weight=1 and enable=1: the MAC in that cycle uses the previous weight_reg. The new weight takes effect from the next cycle.
- quantize_mode may change on any cycle. It applies to the MAC computed at that edge; the stored weight is unaffected.
- Reset asserted mid-operation: all registers clear immediately, including the weight. A reload is required after reset.

Decomposition:
- Shared package:
  - default DATA_WIDTH and ACC_WIDTH constants;
  - quant-mode constants (MODE_INT8=0, MODE_INT4=1);
  - INT4 nibble width constant (4).
- One natural sub-module: pe_mac_unit. It is combinational and contains operand select / sign-extension by mode, the signed multiply, and the accumulate add.
- The top level holds weight_reg, act_out and psum_out.

Test Plan:
1. Reset, enable=1. Load weight 2 for one cycle, then act_in=10, psum_in=0 → after 1 clock psum_out=20.
2. Weight held at 2, act_in=5, psum_in=100 → psum_out=110.
3. Load weight 0xFD (−3), act_in=4, psum_in=0 → psum_out = −12 (0xFFFFFFF4).
4. quantize_mode=1, load weight 0x22, act_in=0x3D, psum_in=0:
   - psum_out = −6 (from 2 × −3);
   - act_out = 0x3D on the same edge.
5. Hold and overlap:
   - enable=0 with changing act_in/psum_in → act_out/psum_out unchanged.
   - load_weight and enable both 1 in the same cycle → that result uses the old weight; the next cycle uses the new one.
6. Boundaries:
   - INT8: weight 0x80 × act 0x80 with psum_in=0x7FFFFFFF → wraps to 0x80003FFF.
   - INT4: weight 0x08 × act 0x08 → +64.
   - Assert rst_n mid-stream → all outputs 0 immediately; after reload of weight 1, act_in=7 gives 7.
